// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: request/stream bundle between a pattern requester and seq_pattern_tx.
//   start, pattern_in, rep_cnt, gap_len : request side, driven by the master.
//   d_out, d_valid, busy, done          : serial stream and framing, driven by the transmitter.
interface seq_pattern_tx_if #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
);
    logic             start;
    logic [PAT_W-1:0] pattern_in;
    logic [CNT_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap_len;
    logic             d_out;
    logic             d_valid;
    logic             busy;
    logic             done;
    modport master (output start, pattern_in, rep_cnt, gap_len, input d_out, d_valid, busy, done);
    modport slave  (input start, pattern_in, rep_cnt, gap_len, output d_out, d_valid, busy, done);
endinterface

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: shifts a W-bit pattern out MSB-first for R repetitions with optional idle gaps.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, aborts any frame without a done pulse
//   tx    : slave side of seq_pattern_tx_if (request inputs, registered serial outputs)
module seq_pattern_tx #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
) (
    input logic             clk,
    input logic             reset,
    seq_pattern_tx_if.slave tx
);
    localparam int BW = $clog2(PAT_W);
    localparam logic [BW-1:0] LAST = BW'(PAT_W - 1);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;
    state_t           state_q;
    logic [PAT_W-1:0] shreg_q, pat_q;
    logic [CNT_W-1:0] reps_q;
    logic [BW-1:0]    bit_q;
    logic [GAP_W-1:0] gap_len_q, gap_cnt_q;
    logic             d_out_q, d_valid_q, busy_q, done_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            pat_q     <= '0;
            reps_q    <= '0;
            bit_q     <= '0;
            gap_len_q <= '0;
            gap_cnt_q <= '0;
            d_out_q   <= 1'b0;
            d_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (tx.start) begin
                        state_q   <= SHIFT;
                        shreg_q   <= tx.pattern_in;
                        pat_q     <= tx.pattern_in;
                        reps_q    <= (tx.rep_cnt == '0) ? CNT_W'(1) : tx.rep_cnt;
                        bit_q     <= '0;
                        gap_len_q <= tx.gap_len;
                        d_out_q   <= tx.pattern_in[PAT_W-1];
                        d_valid_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                // The output flops always show the MSB of shreg_q while in SHIFT, so
                // the next bit is taken from the position below the current MSB.
                SHIFT: begin
                    if (bit_q == LAST) begin
                        bit_q <= '0;
                        if (reps_q > CNT_W'(1)) begin
                            reps_q  <= reps_q - 1'b1;
                            shreg_q <= pat_q;
                            if (gap_len_q != '0) begin
                                state_q   <= GAP;
                                gap_cnt_q <= gap_len_q;
                                d_out_q   <= 1'b0;
                                d_valid_q <= 1'b0;
                            end else begin
                                d_out_q   <= pat_q[PAT_W-1];
                                d_valid_q <= 1'b1;
                            end
                        end else begin
                            state_q   <= DONE;
                            shreg_q   <= shreg_q << 1;
                            d_out_q   <= 1'b0;
                            d_valid_q <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end else begin
                        shreg_q <= shreg_q << 1;
                        bit_q   <= bit_q + 1'b1;
                        d_out_q <= shreg_q[PAT_W-2];
                    end
                end
                // gap_cnt_q is loaded with the gap length on entry, so leaving at 1
                // yields exactly gap_len idle cycles.
                GAP: begin
                    if (gap_cnt_q == GAP_W'(1)) begin
                        state_q   <= SHIFT;
                        gap_cnt_q <= '0;
                        d_out_q   <= shreg_q[PAT_W-1];
                        d_valid_q <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    d_out_q   <= 1'b0;
                    d_valid_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end
    assign tx.d_out   = d_out_q;
    assign tx.d_valid = d_valid_q;
    assign tx.busy    = busy_q;
    assign tx.done    = done_q;
endmodule
